module_wb_arbiter: RTL and testbench
====================================

Name: module_wb_arbiter

Overview:
- Shares the single register-file write port (we3/a3/wd3) between two writeback requesters.
  - Requester 0: ALU result path.
  - Requester 1: load/store unit.
- Requester 0 has fixed priority. An anti-starvation counter forces a grant to requester 1 after STARVE_LIMIT consecutive lost cycles.
- Outputs are registered and drive the register file write port directly.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- STARVE_LIMIT, 4, consecutive cycles requester 1 may be pending and not granted before the next grant is forced to it (legal range 1..15).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has a write pending.
- req0_addr_i  input  ADDR_W  destination register, requester 0.
- req0_data_i  input  DATA_W  write data, requester 0.
- req0_ready_o  output  1  grant to requester 0 (combinational).
- req1_valid_i  input  1  requester 1 has a write pending.
- req1_addr_i  input  ADDR_W  destination register, requester 1.
- req1_data_i  input  DATA_W  write data, requester 1.
- req1_ready_o  output  1  grant to requester 1 (combinational).
- we3_o  output  1  register-file write enable (registered).
- a3_o  output  ADDR_W  register-file write address (registered).
- wd3_o  output  DATA_W  register-file write data (registered).
- starve_o  output  1  pulses one cycle when a forced grant to requester 1 takes place (registered).

Behaviour:
- Reset: while rst_i=1, both ready outputs are 0 combinationally. At the clock edge: we3_o=0, a3_o=0, wd3_o=0, starve_o=0, wait counter=0, FSM=NORMAL.
  - Reset mid-operation discards any accepted-but-not-yet-output write.
- Handshake:
  - A transfer occurs in a cycle where valid=1 and ready=1.
  - A requester holds valid, addr and data stable until accepted.
  - ready depends only on the valid inputs and FSM state, never on outputs.
  - At most one ready is high per cycle.
- FSM states: NORMAL, FORCE1.
  - NORMAL grants:
    - req0_valid_i=1: req0_ready_o=1.
    - Otherwise, req1_valid_i=1: req1_ready_o=1.
  - FORCE1 grants:
    - req1_valid_i=1: req1_ready_o=1 and req0_ready_o=0.
    - req1_valid_i=0 (requester 1 withdrew): NORMAL rules apply.
- Wait counter (4 bits):
  - Increments in a cycle where req1_valid_i=1 and req1_ready_o=0.
  - Clears to 0 on a requester-1 transfer or when req1_valid_i=0.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - NORMAL -> FORCE1 when the counter's next value equals STARVE_LIMIT.
  - FORCE1 -> NORMAL on a requester-1 transfer, or when req1_valid_i=0.
- starve_o=1 in the cycle after a requester-1 transfer granted in FORCE1 while req0_valid_i=1. Otherwise 0.
- Latency:
  - A transfer in cycle N gives we3_o=1, a3_o=addr, wd3_o=data during cycle N+1.
  - The register file captures the write at the end of cycle N+1.
  - Throughput is one write per cycle; back-to-back transfers are supported.
- x0 writes: a transfer with addr=0 is accepted normally, but we3_o stays 0 in cycle N+1.
- Whenever we3_o=0, a3_o=0 and wd3_o=0.
- No transfer in cycle N: we3_o=0 in cycle N+1.
- Simultaneous valids in NORMAL: requester 0 wins; requester 1 waits and its counter increments.

Test Plan:
- Reset: assert rst_i 2 cycles with both valids=1 -> both readies 0 during reset; we3_o=0, a3_o=0, wd3_o=0 after reset.
- Single writes:
  - Requester 0 writes addr=5, data=0xDEADBEEF in cycle N -> req0_ready_o=1 in N; we3_o=1, a3_o=5, wd3_o=0xDEADBEEF in N+1; we3_o=0 in N+2.
- Contention:
  - Both valid, req0 addr=1 and req1 addr=2, req0 re-asserts every cycle -> req0 wins 4 cycles.
  - 5th cycle: req1_ready_o=1, req0_ready_o=0.
  - Next cycle: a3_o=2, starve_o=1; counter returns to 0.
- x0 drop: req1 writes addr=0, data=0x1234 -> req1_ready_o=1; next cycle we3_o=0, a3_o=0, wd3_o=0.
- Back-to-back alternation: req0 addr=3 in N, req1 addr=4 in N+1 (req0 idle) -> we3_o=1 in N+1 and N+2 with a3_o=3 then 4; starve_o stays 0.
- Reset mid-operation: transfer in N, rst_i=1 in N -> we3_o=0 in N+1; wait counter=0 and FSM=NORMAL afterward.

Source files
------------

// File: rtl/module_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : module_wb_arbiter
// Purpose  : Arbitrates the register-file write port between the ALU path
//            (fixed priority) and the load/store unit (anti-starvation).
// Revision : 1.0 - initial release
// ============================================================================
module module_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              we3_o,
    output logic [ADDR_W-1:0] a3_o,
    output logic [DATA_W-1:0] wd3_o,
    output logic              starve_o
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE1 = 1'b1
    } state_t;

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_nxt;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_data_sel;
    logic              w_starve_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_NORMAL;
            r_wait_cnt <= 4'd0;
            we3_o      <= 1'b0;
            a3_o       <= '0;
            wd3_o      <= '0;
            starve_o   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            we3_o      <= w_we_nxt;
            a3_o       <= w_we_nxt ? w_addr_sel : '0;
            wd3_o      <= w_we_nxt ? w_data_sel : '0;
            starve_o   <= w_starve_nxt;
        end
    end

    always_comb begin
        w_grant0       = 1'b0;
        w_grant1       = 1'b0;
        w_wait_cnt_nxt = 4'd0;
        w_state_nxt    = r_state;
        w_addr_sel     = '0;
        w_data_sel     = '0;
        w_we_nxt       = 1'b0;
        w_starve_nxt   = 1'b0;

        // Grants depend only on valids and state; reset masks both.
        if (!rst_i) begin
            if (r_state == ST_FORCE1 && req1_valid_i) begin
                w_grant1 = 1'b1;
            end else if (req0_valid_i) begin
                w_grant0 = 1'b1;
            end else if (req1_valid_i) begin
                w_grant1 = 1'b1;
            end
        end

        if (req1_valid_i && !w_grant1) begin
            w_wait_cnt_nxt = (r_wait_cnt >= c_LIMIT) ? c_LIMIT : r_wait_cnt + 4'd1;
        end

        case (r_state)
            ST_NORMAL: if (w_wait_cnt_nxt == c_LIMIT) w_state_nxt = ST_FORCE1;
            ST_FORCE1: if (w_grant1 || !req1_valid_i) w_state_nxt = ST_NORMAL;
            default:   w_state_nxt = ST_NORMAL;
        endcase

        if (w_grant1) begin
            w_addr_sel = req1_addr_i;
            w_data_sel = req1_data_i;
        end else begin
            w_addr_sel = req0_addr_i;
            w_data_sel = req0_data_i;
        end

        // Writes to x0 are accepted but never reach the register file.
        w_we_nxt     = (w_grant0 || w_grant1) && (w_addr_sel != '0);
        w_starve_nxt = (r_state == ST_FORCE1) && w_grant1 && req0_valid_i;
    end

    assign req0_ready_o = w_grant0;
    assign req1_ready_o = w_grant1;

endmodule
`default_nettype wire

// File: tb/tb_module_wb_arbiter.sv
`default_nettype none
// Randomized and directed bench for module_wb_arbiter against a
// behavioural model of priority, starvation and writeback latency.
module tb_module_wb_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              req0_valid_i = 1'b0;
    logic [ADDR_W-1:0] req0_addr_i = '0;
    logic [DATA_W-1:0] req0_data_i = '0;
    logic              req0_ready_o;
    logic              req1_valid_i = 1'b0;
    logic [ADDR_W-1:0] req1_addr_i = '0;
    logic [DATA_W-1:0] req1_data_i = '0;
    logic              req1_ready_o;
    logic              we3_o;
    logic [ADDR_W-1:0] a3_o;
    logic [DATA_W-1:0] wd3_o;
    logic              starve_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: number of consecutive cycles requester 1 has waited.
    int          lost = 0;
    logic        acc0, acc1;
    logic        exp_we, exp_starve;
    logic [63:0] exp_a, exp_d;

    module_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i),
        .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i),
        .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
        .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o), .starve_o(starve_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic cycle();
        logic forced;
        #1;
        forced = (lost >= STARVE_LIMIT);
        acc1 = !rst_i && req1_valid_i && (forced || !req0_valid_i);
        acc0 = !rst_i && req0_valid_i && !acc1;
        check("req0_ready", 64'(req0_ready_o), 64'(acc0));
        check("req1_ready", 64'(req1_ready_o), 64'(acc1));

        exp_we = 1'b0; exp_a = '0; exp_d = '0; exp_starve = 1'b0;
        if (rst_i) begin
            lost = 0;
        end else begin
            if (acc0 && req0_addr_i != 0) begin
                exp_we = 1'b1; exp_a = 64'(req0_addr_i); exp_d = 64'(req0_data_i);
            end
            if (acc1 && req1_addr_i != 0) begin
                exp_we = 1'b1; exp_a = 64'(req1_addr_i); exp_d = 64'(req1_data_i);
            end
            exp_starve = acc1 && req0_valid_i;
            if (!req1_valid_i || acc1) lost = 0;
            else if (lost < STARVE_LIMIT) lost = lost + 1;
        end

        @(posedge clk);
        #1;
        check("we3", 64'(we3_o), 64'(exp_we));
        check("a3", 64'(a3_o), exp_a);
        check("wd3", 64'(wd3_o), exp_d);
        check("starve", 64'(starve_o), 64'(exp_starve));
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        req0_valid_i = v0; req0_addr_i = a0; req0_data_i = d0;
        req1_valid_i = v1; req1_addr_i = a1; req1_data_i = d1;
    endtask

    initial begin
        // Reset with both requesters asserting.
        rst_i = 1'b1;
        drive(1, 5'd9, 32'h1111_1111, 1, 5'd10, 32'h2222_2222);
        repeat (2) cycle();
        rst_i = 1'b0;

        // Single write, then idle.
        drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0);
        cycle();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cycle();

        // Contention twice: forced grant on the 5th cycle each time.
        for (int rep = 0; rep < 2; rep++) begin
            drive(1, 5'd1, 32'hA0A0_0001, 1, 5'd2, 32'hB0B0_0002);
            for (int c = 0; c < 5; c++) begin
                cycle();
                if (acc1) req1_valid_i = 1'b0;
            end
            check("forced_grant_seen", 64'(acc1), 64'(1));
            check("starve_pulse", 64'(starve_o), 64'(1));
        end

        // Write to x0 is dropped.
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234);
        cycle();

        // Back-to-back alternation.
        drive(1, 5'd3, 32'h0000_0333, 0, 5'd0, 32'h0);
        cycle();
        drive(0, 5'd0, 32'h0, 1, 5'd4, 32'h0000_0444);
        cycle();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cycle();

        // Reset coinciding with a transfer, after building up wait count.
        drive(1, 5'd6, 32'h0000_0666, 1, 5'd8, 32'h0000_0888);
        repeat (3) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        repeat (5) cycle();

        // Randomized traffic respecting the hold-until-accepted rule.
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid_i || acc0) begin
                req0_valid_i = ($urandom_range(0, 3) != 0);
                req0_addr_i  = ADDR_W'($urandom_range(0, 31));
                req0_data_i  = $urandom;
            end
            if (!req1_valid_i || acc1) begin
                req1_valid_i = ($urandom_range(0, 2) != 0);
                req1_addr_i  = ADDR_W'($urandom_range(0, 31));
                req1_data_i  = $urandom;
            end
            // Occasional withdrawal by requester 1 exercises FORCE1 exit.
            if (req1_valid_i && $urandom_range(0, 15) == 0) req1_valid_i = 1'b0;
            rst_i = ($urandom_range(0, 60) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
